// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I-subset controller.
package ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned ALUF_W  = 4;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        HALT
    } state_t;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'h33;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'h13;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'h67;

    localparam logic [ALUF_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALUF_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALUF_W-1:0] ALU_SLT = 4'b0010;

    localparam logic [2:0]         F3_SLT    = 3'b010;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    // Control bundle driven into the datapath each cycle.
    typedef struct packed {
        logic              imem_req;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_write;
        logic              link;
        logic              halted;
        logic [ALUF_W-1:0] alu_control;
    } ctrl_out_t;

    function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE,
            OPC_BRANCH, OPC_JAL, OPC_JALR: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the I/S/B/J field layout from the opcode,
// sign-extends to 32 bits and truncates to the datapath width.
module imm_gen
    import ctrl_pkg::*;
#(
    parameter int unsigned NBITS = 8
) (
    input  logic [INSTR_W-1:0] i_ir,
    output logic [NBITS-1:0]   o_imm_c
);

    logic [INSTR_W-1:0] w_imm32;
    logic               w_unused_funct3;

    assign w_unused_funct3 = ^i_ir[14:12];

    always_comb begin
        w_imm32 = '0;
        case (i_ir[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
            OPC_STORE:
                w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
            OPC_BRANCH:
                w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
            OPC_JAL:
                w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    assign o_imm_c = NBITS'(w_imm32);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM control unit and PC owner for the 8-bit datapath.
// Optional retired-instruction counter enabled by defining INSTRET_COUNTER_EN.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter  int unsigned NBITS      = 8,
    parameter  int unsigned NREGS      = 32,
    parameter  int unsigned WIDTH_ALUF = 4,
    localparam int unsigned IDXW       = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [NBITS-1:0]      imem_addr,
    input  logic                  imem_valid,
    input  logic [INSTR_W-1:0]    imem_rdata,
    output logic [IDXW-1:0]       RS1,
    output logic [IDXW-1:0]       RS2,
    output logic [IDXW-1:0]       RD,
    output logic [NBITS-1:0]      IMM,
    output logic [WIDTH_ALUF-1:0] ALUControl,
    output logic                  ALUSrc,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  link,
    output logic [NBITS-1:0]      pclink,
    input  logic [NBITS-1:0]      PCReg,
    input  logic                  Zero,
    input  logic                  Neg,
    input  logic                  Carry,
    output logic                  halted
`ifdef INSTRET_COUNTER_EN
    ,
    output logic [15:0]           instret
`endif
);

    localparam logic [NBITS-1:0] PC_STEP = NBITS'(4);

    state_t             r_state;
    state_t             w_state_next;
    logic [NBITS-1:0]   r_pc;
    logic [NBITS-1:0]   w_pc_next;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] w_ir_next;
    ctrl_out_t          r_out;
    ctrl_out_t          w_out;
    logic [IDXW-1:0]    r_rs1;
    logic [IDXW-1:0]    r_rs2;
    logic [IDXW-1:0]    r_rd;
    logic [NBITS-1:0]   r_imm;
    logic [NBITS-1:0]   w_imm_next;
    logic [NBITS-1:0]   r_pclink;
    logic               w_taken;
    logic               w_unused_carry;

    imm_gen #(
        .NBITS (NBITS)
    ) u_imm_gen (
        .i_ir    (w_ir_next),
        .o_imm_c (w_imm_next)
    );

    // funct3[2] separates BLT from BEQ
    assign w_taken        = r_ir[14] ? Neg : Zero;
    assign w_unused_carry = Carry;

    // Next state/PC/IR, then the control bundle for the state being entered.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_out        = '0;

        case (r_state)
            FETCH: begin
                if (r_out.imem_req && imem_valid) begin
                    w_ir_next    = imem_rdata;
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                w_state_next = opc_legal(r_ir[6:0]) ? EXEC : HALT;
            end
            EXEC: begin
                w_state_next = FETCH;
                w_pc_next    = r_pc + PC_STEP;
                case (r_ir[6:0])
                    OPC_LOAD, OPC_STORE: begin
                        w_state_next = MEM;
                        w_pc_next    = r_pc;
                    end
                    OPC_BRANCH: begin
                        if (w_taken) w_pc_next = r_pc + r_imm;
                    end
                    OPC_JAL: begin
                        w_pc_next = r_pc + r_imm;
                    end
                    OPC_JALR: begin
                        w_pc_next    = PCReg + r_imm;
                        w_pc_next[0] = 1'b0;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                w_state_next = FETCH;
                w_pc_next    = r_pc + PC_STEP;
            end
            HALT: ;
            default: w_state_next = FETCH;
        endcase

        case (w_state_next)
            FETCH: w_out.imem_req = 1'b1;
            EXEC: begin
                case (w_ir_next[6:0])
                    OPC_OP: begin
                        w_out.reg_write   = 1'b1;
                        w_out.alu_control = (w_ir_next[14:12] == F3_SLT) ? ALU_SLT :
                                            (w_ir_next[30] ? ALU_SUB : ALU_ADD);
                    end
                    OPC_OPIMM: begin
                        w_out.reg_write   = 1'b1;
                        w_out.alu_src     = 1'b1;
                        w_out.alu_control = (w_ir_next[14:12] == F3_SLT) ? ALU_SLT : ALU_ADD;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        w_out.alu_src = 1'b1;
                    end
                    OPC_BRANCH: begin
                        w_out.alu_control = ALU_SUB;
                    end
                    OPC_JAL: begin
                        w_out.link      = 1'b1;
                        w_out.reg_write = 1'b1;
                    end
                    OPC_JALR: begin
                        w_out.link      = 1'b1;
                        w_out.reg_write = 1'b1;
                        w_out.alu_src   = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                // Address path stays as in EXEC; only loads and stores get here
                w_out.alu_src = 1'b1;
                if (w_ir_next[6:0] == OPC_LOAD) begin
                    w_out.mem_to_reg = 1'b1;
                    w_out.reg_write  = 1'b1;
                end else begin
                    w_out.mem_write = 1'b1;
                end
            end
            HALT: w_out.halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= FETCH;
            r_pc     <= '0;
            r_ir     <= INSTR_NOP;
            r_out    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_pclink <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_ir     <= w_ir_next;
            r_out    <= w_out;
            r_rs1    <= IDXW'(w_ir_next[19:15]);
            r_rs2    <= IDXW'(w_ir_next[24:20]);
            r_rd     <= IDXW'(w_ir_next[11:7]);
            r_imm    <= w_imm_next;
            r_pclink <= w_pc_next + PC_STEP;
        end
    end

`ifdef INSTRET_COUNTER_EN
    logic [15:0] r_instret;

    // Counts instructions retired back into FETCH; frozen in HALT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_instret <= '0;
        end else if ((r_state == EXEC || r_state == MEM) && w_state_next == FETCH) begin
            r_instret <= r_instret + 16'd1;
        end
    end

    assign instret = r_instret;
`endif

    assign imem_req   = r_out.imem_req;
    assign imem_addr  = r_pc;
    assign RS1        = r_rs1;
    assign RS2        = r_rs2;
    assign RD         = r_rd;
    assign IMM        = r_imm;
    assign ALUControl = WIDTH_ALUF'(r_out.alu_control);
    assign ALUSrc     = r_out.alu_src;
    assign MemtoReg   = r_out.mem_to_reg;
    assign RegWrite   = r_out.reg_write;
    assign MemWrite   = r_out.mem_write;
    assign link       = r_out.link;
    assign pclink     = r_pclink;
    assign halted     = r_out.halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed plan steps plus random
// instruction streams checked against an architectural PC/control model.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    typedef enum int {K_ADD, K_SUB, K_SLT, K_ADDI, K_SLTI, K_LW, K_SW,
                      K_BEQ, K_BLT, K_JAL, K_JALR} kind_t;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [4:0]  RS1, RS2, RD;
    logic [7:0]  IMM;
    logic [3:0]  ALUControl;
    logic        ALUSrc, MemtoReg, RegWrite, MemWrite, link;
    logic [7:0]  pclink;
    logic [7:0]  PCReg;
    logic        Zero, Neg, Carry;
    logic        halted;
`ifdef INSTRET_COUNTER_EN
    logic [15:0] instret;
`endif

    multicycle_controller #(
        .NBITS      (8),
        .NREGS      (32),
        .WIDTH_ALUF (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .RS1        (RS1),
        .RS2        (RS2),
        .RD         (RD),
        .IMM        (IMM),
        .ALUControl (ALUControl),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .link       (link),
        .pclink     (pclink),
        .PCReg      (PCReg),
        .Zero       (Zero),
        .Neg        (Neg),
        .Carry      (Carry),
        .halted     (halted)
`ifdef INSTRET_COUNTER_EN
        ,
        .instret    (instret)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_instret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input kind_t k, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        case (k)
            K_ADD:  return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            K_SUB:  return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
            K_SLT:  return {7'h00, rs2, rs1, 3'b010, rd, 7'h33};
            K_ADDI: return {imm[11:0], rs1, 3'b000, rd, 7'h13};
            K_SLTI: return {imm[11:0], rs1, 3'b010, rd, 7'h13};
            K_LW:   return {imm[11:0], rs1, 3'b010, rd, 7'h03};
            K_SW:   return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            K_BEQ:  return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
            K_BLT:  return {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], 7'h63};
            K_JAL:  return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
            default: return {imm[11:0], rs1, 3'b000, rd, 7'h67};
        endcase
    endfunction

    task automatic gen_rand(input bit alu_only, output kind_t k,
                            output logic [31:0] w, output logic [31:0] imm);
        logic [31:0] t;
        logic [4:0]  rd, rs1, rs2;
        t   = $urandom;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        k   = alu_only ? kind_t'(int'($urandom_range(0, 4))) : kind_t'(int'($urandom_range(0, 10)));
        case (k)
            K_ADDI, K_SLTI, K_LW, K_SW, K_JALR: imm = {{20{t[11]}}, t[11:0]};
            K_BEQ, K_BLT:                       imm = {{19{t[12]}}, t[12:1], 1'b0};
            K_JAL:                              imm = {{11{t[20]}}, t[20:1], 1'b0};
            default:                            imm = '0;
        endcase
        w = encode(k, rd, rs1, rs2, imm);
    endtask

    // Wait for the request of a new fetch; it must follow the previous instruction immediately.
    task automatic wait_fetch();
        int n = 0;
        @(negedge clock);
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("fetch_gap", n, 0);
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_no_en", {RegWrite, MemWrite, MemtoReg, link, halted}, 0);
`ifdef INSTRET_COUNTER_EN
        chk("instret", instret, m_instret);
`endif
    endtask

    task automatic run_instr(input kind_t k, input logic [31:0] w, input logic [31:0] imm,
                             input int wt, input logic zero, input logic neg,
                             input logic [7:0] pcreg);
        logic [7:0] imm8, link8, npc, tgt;
        logic [3:0] exp_alu;
        bit         is_r, is_alu, is_j, is_mem, exp_src;
        imm8   = imm[7:0];
        link8  = m_pc + 8'd4;
        is_r   = (k inside {K_ADD, K_SUB, K_SLT});
        is_alu = (k inside {K_ADD, K_SUB, K_SLT, K_ADDI, K_SLTI});
        is_j   = (k inside {K_JAL, K_JALR});
        is_mem = (k inside {K_LW, K_SW});
        exp_src = (k inside {K_ADDI, K_SLTI, K_LW, K_SW});
        case (k)
            K_SUB, K_BEQ, K_BLT: exp_alu = ALU_SUB;
            K_SLT, K_SLTI:       exp_alu = ALU_SLT;
            default:             exp_alu = ALU_ADD;
        endcase

        wait_fetch();
        for (int i = 0; i < wt; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            @(negedge clock);
            chk("fetch_hold_req", imem_req, 1);
            chk("fetch_hold_addr", imem_addr, m_pc);
        end
        imem_valid = 1'b1;
        imem_rdata = w;
        @(negedge clock);

        // decode cycle; imem_valid noise here must be ignored
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        Zero  = zero;
        Neg   = neg;
        PCReg = pcreg;
        Carry = 1'($urandom_range(0, 1));
        chk("dec_req", imem_req, 0);
        chk("dec_en", {RegWrite, MemWrite, MemtoReg, link, halted}, 0);
        chk("dec_rs1", RS1, w[19:15]);
        chk("dec_rs2", RS2, w[24:20]);
        chk("dec_rd", RD, w[11:7]);

        @(negedge clock);
        imem_valid = 1'($urandom_range(0, 1));
        chk("exec_req", imem_req, 0);
        chk("exec_halted", halted, 0);
        chk("exec_rs1", RS1, w[19:15]);
        chk("exec_rs2", RS2, w[24:20]);
        chk("exec_rd", RD, w[11:7]);
        if (!is_r) chk("exec_imm", IMM, imm8);
        chk("exec_mem_en", {MemWrite, MemtoReg}, 0);
        chk("exec_link", link, is_j);
        chk("exec_regwrite", RegWrite, is_alu || is_j);
        if (!is_j) begin
            chk("exec_alu", ALUControl, exp_alu);
            chk("exec_alusrc", ALUSrc, exp_src);
        end else begin
            chk("exec_pclink", pclink, link8);
        end

        if (is_mem) begin
            @(negedge clock);
            imem_valid = 1'($urandom_range(0, 1));
            chk("mem_req", imem_req, 0);
            chk("mem_rd", RD, w[11:7]);
            chk("mem_rs1", RS1, w[19:15]);
            chk("mem_imm", IMM, imm8);
            chk("mem_memtoreg", MemtoReg, k == K_LW);
            chk("mem_regwrite", RegWrite, k == K_LW);
            chk("mem_memwrite", MemWrite, k == K_SW);
            chk("mem_link", link, 0);
            chk("mem_alu", ALUControl, ALU_ADD);
            chk("mem_alusrc", ALUSrc, 1);
        end

        case (k)
            K_BEQ:   npc = zero ? m_pc + imm8 : m_pc + 8'd4;
            K_BLT:   npc = neg ? m_pc + imm8 : m_pc + 8'd4;
            K_JAL:   npc = m_pc + imm8;
            K_JALR: begin
                tgt = pcreg + imm8;
                npc = tgt & 8'hFE;
            end
            default: npc = m_pc + 8'd4;
        endcase
        m_pc      = npc;
        m_instret = m_instret + 16'd1;
    endtask

    task automatic run_random(input bit alu_only);
        kind_t       k;
        logic [31:0] w, imm;
        gen_rand(alu_only, k, w, imm);
        run_instr(k, w, imm, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic fill_to(input logic [7:0] target);
        int guard = 0;
        while (m_pc != target && guard < 64) begin
            run_random(1'b1);
            guard++;
        end
    endtask

    task automatic do_reset(input int cycles);
        reset      = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'h0050_0093;
        repeat (cycles) @(negedge clock);
        chk("rst_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_en", {RegWrite, MemWrite, MemtoReg, link, ALUSrc}, 0);
        chk("rst_alu", ALUControl, 0);
        chk("rst_imm", IMM, 0);
        chk("rst_pclink", pclink, 0);
        chk("rst_regs", {RS1, RS2, RD}, 0);
`ifdef INSTRET_COUNTER_EN
        chk("rst_instret", instret, 0);
`endif
        reset      = 1'b1;
        imem_valid = 1'b0;
        m_pc       = 8'h00;
        m_instret  = 16'd0;
    endtask

    task automatic run_halt();
        wait_fetch();
        imem_valid = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        imem_valid = 1'b0;
        chk("halt_dec_req", imem_req, 0);
        chk("halt_dec_halted", halted, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = 32'h0050_0093;
            chk("halt_halted", halted, 1);
            chk("halt_req", imem_req, 0);
            chk("halt_en", {RegWrite, MemWrite, MemtoReg, link}, 0);
            chk("halt_pc", imem_addr, m_pc);
`ifdef INSTRET_COUNTER_EN
            chk("halt_instret", instret, m_instret);
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        reset      = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        PCReg      = '0;
        Zero       = 1'b0;
        Neg        = 1'b0;
        Carry      = 1'b0;
        m_pc       = 8'h00;
        m_instret  = 16'd0;

        do_reset(2);

        // addi x1,x0,5 after two wait cycles
        run_instr(K_ADDI, 32'h0050_0093, 32'd5, 2, 1'b0, 1'b0, 8'h00);

        // beq x1,x2,-8 at 0x10, taken then not taken
        fill_to(8'h10);
        w = encode(K_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        run_instr(K_BEQ, w, 32'hFFFF_FFF8, 0, 1'b1, 1'b0, 8'h00);
        fill_to(8'h10);
        run_instr(K_BEQ, w, 32'hFFFF_FFF8, 1, 1'b0, 1'b1, 8'h00);

        // jal x1,+12 at 0x20, then jalr x0,0(x5) with rs1 = 0x41
        fill_to(8'h20);
        w = encode(K_JAL, 5'd1, 5'd0, 5'd0, 32'd12);
        run_instr(K_JAL, w, 32'd12, 0, 1'b0, 1'b0, 8'h00);
        w = encode(K_JALR, 5'd0, 5'd5, 5'd0, 32'd0);
        run_instr(K_JALR, w, 32'd0, 0, 1'b0, 1'b0, 8'h41);

        // lw x3,4(x2) and sw x4,8(x2)
        w = encode(K_LW, 5'd3, 5'd2, 5'd0, 32'd4);
        run_instr(K_LW, w, 32'd4, 1, 1'b0, 1'b0, 8'h00);
        w = encode(K_SW, 5'd0, 5'd2, 5'd4, 32'd8);
        run_instr(K_SW, w, 32'd8, 0, 1'b0, 1'b0, 8'h00);

        repeat (150) run_random(1'b0);

        run_halt();

        do_reset(1);
        repeat (3) run_random(1'b0);

        // reset while a fetch is being answered abandons it
        wait_fetch();
        imem_valid = 1'b1;
        imem_rdata = 32'h0050_0093;
        reset      = 1'b0;
        @(negedge clock);
        chk("midrst_req", imem_req, 0);
        chk("midrst_addr", imem_addr, 0);
        chk("midrst_en", {RegWrite, MemWrite, MemtoReg, link, halted}, 0);
        reset      = 1'b1;
        imem_valid = 1'b0;
        m_pc       = 8'h00;
        m_instret  = 16'd0;
        repeat (3) run_random(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
